// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg: shared constants, slot state encoding and round-robin pick helper.
`default_nettype none

package shift_arbiter_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Upper bound on requesters the pick helper can scan.
  localparam int MAX_REQ = 64;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  // First asserted valid bit at or after ptr, wrapping modulo nreq.
  // Returns ptr when nothing is valid; callers gate with the valid bit.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                 input int ptr,
                                 input int nreq);
    int idx;
    rr_pick = ptr;
    // Scan from the farthest offset down so the nearest hit wins last.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = ptr + k;
        if (idx >= nreq) idx = idx - nreq;
        if (valid[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shift_core.sv
// barrel_shift_core: combinational logical barrel shifter, zero fill, log2 mux stages.
`default_nettype none

module barrel_shift_core
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    shift_amt,
  input  logic             dir,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage [0:AW];

  assign stage[0] = data_in;

  for (genvar s = 0; s < AW; s++) begin : g_stage
    assign stage[s+1] = !shift_amt[s]     ? stage[s] :
                        (dir == DIR_RIGHT) ? (stage[s] >> (1 << s)) :
                                             (stage[s] << (1 << s));
  end

  assign data_out = stage[AW];

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one barrel shifter among NREQ requesters,
// with a single registered result slot under valid/ready backpressure.
`default_nettype none

module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  localparam int AW = $clog2(WIDTH),
  localparam int IW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*AW-1:0]    req_amt,
  input  logic [NREQ-1:0]       req_dir,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic [IW-1:0]         resp_id
);

  slot_state_t      state;
  slot_state_t      state_next;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    grant;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [AW-1:0]    sel_amt;
  logic             sel_dir;
  logic [WIDTH-1:0] shifted;

  assign resp_valid = (state == ST_FULL);
  assign slot_free  = (state == ST_EMPTY) || resp_ready;

  assign grant     = IW'(rr_pick(MAX_REQ'(req_valid), int'(rr_ptr), NREQ));
  assign accept    = req_valid[grant] && slot_free;
  assign req_ready = slot_free ? ((NREQ'(1) << grant) & req_valid) : '0;

  assign sel_data = req_data[grant*WIDTH +: WIDTH];
  assign sel_amt  = req_amt[grant*AW +: AW];
  assign sel_dir  = req_dir[grant];

  barrel_shift_core #(
    .WIDTH (WIDTH)
  ) u_shift (
    .data_in   (sel_data),
    .shift_amt (sel_amt),
    .dir       (sel_dir),
    .data_out  (shifted)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL: begin
        if (accept)          state_next = ST_FULL;
        else if (resp_ready) state_next = ST_EMPTY;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      resp_data <= '0;
      resp_id   <= '0;
      rr_ptr    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        resp_data <= shifted;
        resp_id   <= grant;
        rr_ptr    <= (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed self-checking bench for shift_arbiter (WIDTH=4, NREQ=4).
`default_nettype none

module tb_shift_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int AW    = 2;
  localparam int IW    = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*AW-1:0]    req_amt;
  logic [NREQ-1:0]       req_dir;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WIDTH-1:0]      resp_data;
  logic [IW-1:0]         resp_id;

  int n_cmp = 0;
  int n_err = 0;

  shift_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .req_dir    (req_dir),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 4'($urandom);
    req_data   = 16'($urandom);
    req_amt    = 8'($urandom);
    req_dir    = 4'($urandom);
    resp_ready = 1'($urandom);
    step();
    step();
    req_valid = '0;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_data !== 4'b0000) begin n_err++; $display("FAIL reset_data: got %b want 0000", resp_data); end
    n_cmp++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", resp_id); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [1:0] amts [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd0};
    logic       dirs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] exps [5] = '{4'b0100, 4'b0110, 4'b1000, 4'b0011, 4'b1101};
    resp_ready = 1'b1;
    req_data   = '0;
    req_amt    = '0;
    req_dir    = '0;
    for (int i = 0; i < 5; i++) begin
      req_data[3:0] = 4'b1101;
      req_amt[1:0]  = amts[i];
      req_dir[0]    = dirs[i];
      req_valid     = 4'b0001;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready[%0d]: got %b want 0001", i, req_ready); end
      step();
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d]: got %b want 1", i, resp_valid); end
      n_cmp++; if (resp_data !== exps[i]) begin n_err++; $display("FAIL single_data[%0d]: got %b want %b", i, resp_data, exps[i]); end
      n_cmp++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL single_id[%0d]: got %0d want 0", i, resp_id); end
    end
    req_valid = '0;
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", resp_valid); end
    n_cmp++; if (resp_data !== 4'b1101) begin n_err++; $display("FAIL single_hold: got %b want 1101", resp_data); end
  endtask

  // Per-requester results: 0001<<0, 0011<<1, 0111>>2, 1001<<3.
  logic [3:0] rr_exp [4] = '{4'b0001, 4'b0110, 4'b0001, 4'b1000};

  task automatic load_rr_fields();
    req_data = {4'b1001, 4'b0111, 4'b0011, 4'b0001};
    req_amt  = {2'd3, 2'd2, 2'd1, 2'd0};
    req_dir  = 4'b0100;
  endtask

  task automatic test_round_robin();
    logic [1:0] seq_all  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] seq_skip [6] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0};
    req_valid = '0;
    do_reset();
    load_rr_fields();
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", i, resp_valid); end
      n_cmp++; if (resp_id !== seq_all[i]) begin n_err++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, resp_id, seq_all[i]); end
      n_cmp++; if (resp_data !== rr_exp[seq_all[i]]) begin n_err++; $display("FAIL rr_data[%0d]: got %b want %b", i, resp_data, rr_exp[seq_all[i]]); end
    end
    req_valid = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (resp_id !== seq_skip[i]) begin n_err++; $display("FAIL rr_skip_id[%0d]: got %0d want %0d", i, resp_id, seq_skip[i]); end
      n_cmp++; if (resp_data !== rr_exp[seq_skip[i]]) begin n_err++; $display("FAIL rr_skip_data[%0d]: got %b want %b", i, resp_data, rr_exp[seq_skip[i]]); end
    end
  endtask

  task automatic test_backpressure();
    // Slot holds requester 0's result; pointer now at 1 with req1 dropped.
    resp_ready = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready_pre: got %b want 0000", req_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, resp_valid); end
      n_cmp++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL bp_id[%0d]: got %0d want 0", i, resp_id); end
      n_cmp++; if (resp_data !== 4'b0001) begin n_err++; $display("FAIL bp_data[%0d]: got %b want 0001", i, resp_data); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, req_ready); end
    end
    resp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release_ready: got %b want 0100", req_ready); end
    step();
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_nobubble_valid: got %b want 1", resp_valid); end
    n_cmp++; if (resp_id !== 2'd2) begin n_err++; $display("FAIL bp_nobubble_id: got %0d want 2", resp_id); end
    n_cmp++; if (resp_data !== 4'b0001) begin n_err++; $display("FAIL bp_nobubble_data: got %b want 0001", resp_data); end
  endtask

  task automatic test_reset_mid();
    req_valid = '0;
    do_reset();
    load_rr_fields();
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    step();
    step();
    n_cmp++; if (resp_id !== 2'd1) begin n_err++; $display("FAIL mid_setup_id: got %0d want 1", resp_id); end
    rst_n = 1'b0;
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_data !== 4'b0000) begin n_err++; $display("FAIL mid_data: got %b want 0000", resp_data); end
    n_cmp++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL mid_id: got %0d want 0", resp_id); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_ready: got %b want 0001", req_ready); end
    step();
    n_cmp++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL mid_first_id: got %0d want 0", resp_id); end
    n_cmp++; if (resp_data !== 4'b0001) begin n_err++; $display("FAIL mid_first_data: got %b want 0001", resp_data); end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_amt    = '0;
    req_dir    = '0;
    resp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
